mmio_uart_bridge: RTL and testbench
===================================

MMIO_UART_BRIDGE -- requirements
Module: mmio_uart_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2000_0000; base of the 16-byte register window.
REQ-002 SHALL have parameter TX_DEPTH, default 16; TX FIFO entries, power of two, 2..256.
REQ-003 SHALL have parameter RX_DEPTH, default 16; RX FIFO entries, power of two, 2..256.
REQ-004 SHALL have parameter TX_BLOCKING, default 1; 1 = stall writes to a full TX FIFO, 0 = drop them.
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-007 SHALL have ports mem_valid in 1, mem_addr in 32, mem_wdata in 32, mem_wstrb in 4, mem_ready out 1, mem_rdata out 32; the picorv32 native bus.
REQ-008 SHALL have ports tx_tdata out 8, tx_tvalid out 1, tx_tready in 1; an AXI-stream to the uart transmitter.
REQ-009 SHALL have ports rx_tdata in 8, rx_tvalid in 1, rx_tready out 1; an AXI-stream from the uart receiver.
REQ-010 SHALL have port irq  output  1  level interrupt.

Function
REQ-011 SHALL claim an access only when mem_valid=1 and mem_addr[31:4]==BASE_ADDR[31:4]; mem_ready SHALL stay 0 for all other addresses.
REQ-012 SHALL assert mem_ready for exactly one cycle per claimed access, in the cycle after the claim; mem_rdata SHALL be valid in that same cycle and SHALL be 0 on writes.
REQ-013 SHALL map offset 0x0 DATA: a write (any wstrb) pushes wdata[7:0] to the TX FIFO; a read pops the RX FIFO and returns {bit8=1, data[7:0]}, or returns 0x0000_0000 with no pop if the FIFO is empty (non-blocking).
REQ-014 SHALL map offset 0x4 STATUS (read-only): bit0 rx_nonempty, bit1 tx_notfull, bit2 tx_empty, bit3 rx_overflow (sticky), bit4 tx_drop (sticky), [15:8] rx_count, [23:16] tx_count; writes to STATUS SHALL be acknowledged and ignored.
REQ-015 SHALL map offset 0x8 CTRL: bit0 rx_irq_en, bit1 txe_irq_en (read/write); writing 1 to bit2 clears rx_overflow and writing 1 to bit3 clears tx_drop, and bits 2-3 SHALL read as 0.
REQ-016 SHALL map offset 0xC as reserved: reads return 0, writes are acknowledged and ignored.
REQ-017 SHALL stall a DATA write while the TX FIFO is full when TX_BLOCKING=1, and SHALL acknowledge it one cycle after space appears.
REQ-018 SHALL, when TX_BLOCKING=0, acknowledge a DATA write to a full TX FIFO, discard the data, and set tx_drop.
REQ-019 SHALL drive tx_tvalid=1 whenever the TX FIFO is non-empty with tx_tdata = head entry, and SHALL pop on tx_tvalid&&tx_tready.
REQ-020 SHALL hold rx_tready=1 at all times; a beat arriving while the RX FIFO is full SHALL be discarded and SHALL set rx_overflow.
REQ-021 SHALL, on a simultaneous push and pop in one cycle, perform both and leave the count unchanged, including when the FIFO is full (TX side) or empty (no pop).
REQ-022 SHALL use free-running pointers one bit wider than log2(depth) that wrap modulo 2*depth; count = wptr - rptr.
REQ-023 SHALL drive irq = (rx_irq_en & rx_nonempty) | (txe_irq_en & tx_empty), registered, with one-cycle latency.
REQ-024 SHALL implement the bus FSM states IDLE -> ACK -> IDLE, plus IDLE -> WAIT_TX -> ACK for a blocked write; mem_valid must not be re-sampled in ACK.

Reset
REQ-025 SHALL, when resetn=0 at a clk edge, set both FIFOs empty, clear CTRL, rx_overflow and tx_drop, and the FSM to IDLE; mem_ready=0, mem_rdata=0, tx_tvalid=0, irq=0.
REQ-026 SHALL, on reset asserted mid-access, abandon the access with no ack; FIFO contents are lost.
REQ-027 SHALL deassert rx_tready during reset.

Structure
REQ-028 SHALL place the register offsets, STATUS/CTRL bit positions, and FSM state encodings in the shared package mmio_pkg.
REQ-029 SHALL instantiate the sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, count) twice, for TX and RX.

Verification
REQ-030 Reset, then write DATA=0x41, 0x42 with tx_tready=1 -> tx_tdata 0x41 then 0x42; STATUS reads tx_empty=1 afterwards.
REQ-031 tx_tready=0, TX_BLOCKING=1, 17 DATA writes -> 16 acked, 17th stalls; raise tx_tready -> 17th acked after one pop.
REQ-032 TX_BLOCKING=0, same stimulus -> all 17 acked, tx_drop=1; CTRL write 0x8 -> tx_drop=0.
REQ-033 Push 17 RX beats without reads -> rx_count=16, rx_overflow=1; 16 DATA reads return 0x1xx in order; 17th read returns 0x0.
REQ-034 CTRL=0x1, one RX beat -> irq=1 next cycle; DATA read -> irq=0; access to BASE+0x10 -> mem_ready never asserts.
REQ-035 Assert resetn=0 while a write is stalled in WAIT_TX -> no ack; FIFOs empty and all outputs at reset values.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO UART bridge: register map, bit positions, bus FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mmio_pkg;

    // Register index within the 16-byte window (mem_addr[3:2]).
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions.
    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_TX_NOTFULL   = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_RX_OVERFLOW  = 3;
    localparam int ST_TX_DROP      = 4;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    // CTRL bit positions; the two clear bits are write-one-to-clear strobes.
    localparam int CTRL_RX_IRQ_EN   = 0;
    localparam int CTRL_TXE_IRQ_EN  = 1;
    localparam int CTRL_CLR_RX_OVF  = 2;
    localparam int CTRL_CLR_TX_DROP = 3;

    typedef enum logic [1:0] {
        BUS_IDLE    = 2'd0,
        BUS_ACK     = 2'd1,
        BUS_WAIT_TX = 2'd2
    } bus_state_t;

    // A 256-deep FIFO holds 256 entries, which does not fit the 8-bit
    // STATUS count fields; report 255 in that single case.
    function automatic logic [7:0] sat_count8(input logic [8:0] c);
        return (c > 9'd255) ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with free-running wrap-around pointers and a combinational head read.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop on empty is ignored.
//   ports: clk, resetn (sync, active-low), push/push_data, pop/head, full, empty, count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit, so the difference is the occupancy
    // and equal pointers unambiguously mean empty.
    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// picorv32 native-bus register window in front of a UART TX/RX stream pair, with TX and RX FIFOs and a level irq.
// Latency: mem_ready one cycle after the claim; a DATA write to a full TX FIFO waits (blocking) or is dropped.
// Backpressure: tx stream honours tx_tready; rx_tready is always 1 out of reset and overflowing beats are discarded.
//   ports: clk, resetn; mem_* picorv32 bus; tx_t* stream out; rx_t* stream in; irq
module mmio_uart_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          TX_DEPTH    = 16,
    parameter int          RX_DEPTH    = 16,
    parameter int          TX_BLOCKING = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic        irq
);

    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic       tx_full, tx_empty, tx_push, tx_pop;
    logic       rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0] tx_push_data, rx_head;

    bus_state_t  state;
    logic        rx_irq_en, txe_irq_en;
    logic        rx_overflow, tx_drop;
    logic [7:0]  pend_data;
    logic [31:0] status_word;

    logic       claim, is_wr, data_wr, data_rd;
    logic [1:0] reg_sel;
    logic       unused_bits;

    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

    assign claim   = (state == BUS_IDLE) && mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign is_wr   = |mem_wstrb;
    assign reg_sel = mem_addr[3:2];
    assign data_wr = claim && is_wr && (reg_sel == REG_DATA);
    assign data_rd = claim && !is_wr && (reg_sel == REG_DATA);

    // A stalled write pushes the byte captured at claim time, not whatever
    // is on mem_wdata later.
    assign tx_push      = (data_wr && !tx_full) || ((state == BUS_WAIT_TX) && !tx_full);
    assign tx_push_data = (state == BUS_WAIT_TX) ? pend_data : mem_wdata[7:0];
    assign tx_tvalid    = !tx_empty;
    assign tx_pop       = tx_tvalid && tx_tready;

    // A beat arriving on a full RX FIFO is lost even if a read pops in the
    // same cycle; the overflow flag reports it.
    assign rx_push = rx_tvalid && rx_tready && !rx_full;
    assign rx_pop  = data_rd && !rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .head      (tx_tdata),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rx_push),
        .push_data (rx_tdata),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        status_word = '0;
        status_word[ST_RX_NONEMPTY] = !rx_empty;
        status_word[ST_TX_NOTFULL]  = !tx_full;
        status_word[ST_TX_EMPTY]    = tx_empty;
        status_word[ST_RX_OVERFLOW] = rx_overflow;
        status_word[ST_TX_DROP]     = tx_drop;
        status_word[ST_RX_COUNT_LSB +: 8] = sat_count8(9'(rx_count));
        status_word[ST_TX_COUNT_LSB +: 8] = sat_count8(9'(tx_count));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= BUS_IDLE;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            rx_irq_en   <= 1'b0;
            txe_irq_en  <= 1'b0;
            rx_overflow <= 1'b0;
            tx_drop     <= 1'b0;
            pend_data   <= '0;
            irq         <= 1'b0;
            rx_tready   <= 1'b0;
        end else begin
            rx_tready <= 1'b1;
            irq       <= (rx_irq_en && !rx_empty) || (txe_irq_en && tx_empty);

            case (state)
                BUS_IDLE: begin
                    if (claim) begin
                        state     <= BUS_ACK;
                        mem_ready <= 1'b1;
                        mem_rdata <= '0;
                        case (reg_sel)
                            REG_DATA: begin
                                if (is_wr) begin
                                    if (tx_full) begin
                                        if (TX_BLOCKING != 0) begin
                                            state     <= BUS_WAIT_TX;
                                            mem_ready <= 1'b0;
                                            pend_data <= mem_wdata[7:0];
                                        end else begin
                                            tx_drop <= 1'b1;
                                        end
                                    end
                                end else if (!rx_empty) begin
                                    mem_rdata <= {23'd0, 1'b1, rx_head};
                                end
                            end
                            REG_STATUS: begin
                                if (!is_wr) mem_rdata <= status_word;
                            end
                            REG_CTRL: begin
                                if (is_wr) begin
                                    rx_irq_en  <= mem_wdata[CTRL_RX_IRQ_EN];
                                    txe_irq_en <= mem_wdata[CTRL_TXE_IRQ_EN];
                                    if (mem_wdata[CTRL_CLR_RX_OVF])  rx_overflow <= 1'b0;
                                    if (mem_wdata[CTRL_CLR_TX_DROP]) tx_drop     <= 1'b0;
                                end else begin
                                    mem_rdata <= {30'd0, txe_irq_en, rx_irq_en};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                BUS_WAIT_TX: begin
                    if (!tx_full) begin
                        state     <= BUS_ACK;
                        mem_ready <= 1'b1;
                    end
                end
                // The master may still hold mem_valid here; it is deliberately not looked at.
                BUS_ACK: begin
                    state     <= BUS_IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= '0;
                end
                default: state <= BUS_IDLE;
            endcase

            // Placed last so a new overflow beats a same-cycle software clear.
            if (rx_tvalid && rx_tready && rx_full) rx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Self-checking bench for mmio_uart_bridge: one blocking and one dropping instance, queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mmio_uart_bridge;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        tx_tready, rx_tvalid;
    logic [7:0]  rx_tdata;
    bit          sel;   // 0: blocking instance, 1: dropping instance

    logic        a_valid, a_ready, a_txv, a_txr, a_rxv, a_rxr, a_irq;
    logic [31:0] a_rdata;
    logic [7:0]  a_txd;
    logic        b_valid, b_ready, b_txv, b_txr, b_rxv, b_rxr, b_irq;
    logic [31:0] b_rdata;
    logic [7:0]  b_txd;

    assign a_valid = mem_valid && !sel;
    assign a_txr   = tx_tready && !sel;
    assign a_rxv   = rx_tvalid && !sel;
    assign b_valid = mem_valid && sel;
    assign b_txr   = tx_tready && sel;
    assign b_rxv   = rx_tvalid && sel;

    logic        mem_ready, tx_tvalid, rx_tready, irq;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_tdata;
    assign mem_ready = sel ? b_ready : a_ready;
    assign mem_rdata = sel ? b_rdata : a_rdata;
    assign tx_tvalid = sel ? b_txv   : a_txv;
    assign tx_tdata  = sel ? b_txd   : a_txd;
    assign rx_tready = sel ? b_rxr   : a_rxr;
    assign irq       = sel ? b_irq   : a_irq;

    mmio_uart_bridge #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .TX_BLOCKING(1)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(a_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(a_ready), .mem_rdata(a_rdata),
        .tx_tdata(a_txd), .tx_tvalid(a_txv), .tx_tready(a_txr),
        .rx_tdata(rx_tdata), .rx_tvalid(a_rxv), .rx_tready(a_rxr),
        .irq(a_irq)
    );

    mmio_uart_bridge #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .TX_BLOCKING(0)) dut_drop (
        .clk(clk), .resetn(resetn),
        .mem_valid(b_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(b_ready), .mem_rdata(b_rdata),
        .tx_tdata(b_txd), .tx_tvalid(b_txv), .tx_tready(b_txr),
        .rx_tdata(rx_tdata), .rx_tvalid(b_rxv), .rx_tready(b_rxr),
        .irq(b_irq)
    );

    // ---------------- reference model ----------------
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] seen_q[$];
    bit m_ovf, m_drop, m_rx_en, m_txe_en;
    bit rnd;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_model();
        logic [31:0] s;
        s = '0;
        s[0] = (rx_q.size() != 0);
        s[1] = (tx_q.size() < DEPTH);
        s[2] = (tx_q.size() == 0);
        s[3] = m_ovf;
        s[4] = m_drop;
        s[15:8]  = 8'(rx_q.size());
        s[23:16] = 8'(tx_q.size());
        return s;
    endfunction

    // One clock: predict stream effects from pre-edge model state, advance to next negedge, check irq.
    task automatic cycle();
        logic exp_irq;
        if (rnd) begin
            rx_tvalid = ($urandom_range(0, 3) == 0);
            rx_tdata  = 8'($urandom);
            tx_tready = ($urandom_range(0, 2) != 0);
        end
        exp_irq = (m_rx_en && rx_q.size() != 0) || (m_txe_en && tx_q.size() == 0);
        check("tx_tvalid", tx_tvalid, tx_q.size() != 0);
        if (tx_tvalid && tx_tready && tx_q.size() != 0) begin
            check("tx_tdata", tx_tdata, tx_q[0]);
            seen_q.push_back(tx_q.pop_front());
        end
        if (rx_tvalid) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(rx_tdata);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
        check("irq", irq, exp_irq);
    endtask

    task automatic access(input bit wr, input logic [3:0] off, input logic [31:0] wd,
                          output logic [31:0] rd);
        logic [31:0] exp;
        bit pop_rx, push_tx, drop, stall;
        int n;
        exp = '0; pop_rx = 0; push_tx = 0; drop = 0; stall = 0;
        case (off[3:2])
            2'd0: begin
                if (wr) begin
                    if (tx_q.size() >= DEPTH) begin
                        if (sel) drop = 1;
                        else begin stall = 1; push_tx = 1; end
                    end else push_tx = 1;
                end else if (rx_q.size() != 0) begin
                    exp = 32'h100 | 32'(rx_q[0]);
                    pop_rx = 1;
                end
            end
            2'd1: if (!wr) exp = status_model();
            2'd2: begin
                if (wr) begin
                    if (wd[2]) m_ovf  = 1'b0;
                    if (wd[3]) m_drop = 1'b0;
                end else exp = {30'd0, m_txe_en, m_rx_en};
            end
            default: ;
        endcase
        mem_addr  = BASE | 32'(off);
        mem_wdata = wd;
        mem_wstrb = wr ? 4'hF : 4'h0;
        mem_valid = 1'b1;
        cycle();
        n = 1;
        if (pop_rx) void'(rx_q.pop_front());
        while (!mem_ready && n < 200) begin
            cycle();
            n++;
        end
        mem_valid = 1'b0;
        check("ack", mem_ready, 1);
        check("ack_latency", stall ? (n > 1) : (n == 1), 1);
        check("rdata", mem_rdata, exp);
        if (mem_ready) begin
            if (push_tx) tx_q.push_back(wd[7:0]);
            if (drop) m_drop = 1'b1;
            if (wr && off[3:2] == 2'd2) begin
                m_rx_en  = wd[0];
                m_txe_en = wd[1];
            end
        end
        rd = mem_rdata;
        cycle();
        check("ready_pulse", mem_ready, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0; mem_valid = 1'b0; rx_tvalid = 1'b0; tx_tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_tx_tvalid", tx_tvalid, 0);
        check("rst_irq", irq, 0);
        check("rst_rx_tready", rx_tready, 0);
        tx_q.delete(); rx_q.delete();
        m_ovf = 0; m_drop = 0; m_rx_en = 0; m_txe_en = 0;
        resetn = 1'b1;
        @(negedge clk);
        check("rx_tready_run", rx_tready, 1);
    endtask

    task automatic drain();
        tx_tready = 1'b1;
        for (int k = 0; k < 60 && tx_q.size() != 0; k++) cycle();
        cycle();
        check("tx_drained", tx_tvalid, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit ok;
        int n;

        tbl[0]  = '{0, 4'h4, 32'h0,         32'h0000_0006};
        tbl[1]  = '{0, 4'h8, 32'h0,         32'h0};
        tbl[2]  = '{0, 4'hC, 32'h0,         32'h0};
        tbl[3]  = '{0, 4'h0, 32'h0,         32'h0};
        tbl[4]  = '{1, 4'h8, 32'h3,         32'h0};
        tbl[5]  = '{0, 4'h8, 32'h0,         32'h3};
        tbl[6]  = '{1, 4'h8, 32'hF,         32'h0};
        tbl[7]  = '{0, 4'h8, 32'h0,         32'h3};
        tbl[8]  = '{1, 4'h4, 32'hFFFF_FFFF, 32'h0};
        tbl[9]  = '{0, 4'h4, 32'h0,         32'h0000_0006};
        tbl[10] = '{1, 4'hC, 32'hFFFF_FFFF, 32'h0};
        tbl[11] = '{0, 4'hC, 32'h0,         32'h0};
        tbl[12] = '{1, 4'h8, 32'h0,         32'h0};
        tbl[13] = '{0, 4'h8, 32'h0,         32'h0};

        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0; sel = 0; rnd = 0;

        // Register map after reset
        do_reset();
        for (int i = 0; i < 14; i++) begin
            access(tbl[i].wr, tbl[i].off, tbl[i].wd, rd);
            check($sformatf("table_%0d", i), rd, tbl[i].exp);
        end

        // Two bytes out on the TX stream
        do_reset();
        seen_q.delete();
        tx_tready = 1'b1;
        access(1, 4'h0, 32'h41, rd);
        access(1, 4'h0, 32'h42, rd);
        for (int k = 0; k < 3; k++) cycle();
        check("tx_seen_count", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            check("tx_first", seen_q[0], 8'h41);
            check("tx_second", seen_q[1], 8'h42);
        end
        access(0, 4'h4, 0, rd);
        check("tx_empty_after", rd[2], 1);

        // Blocking: 17th write stalls until one pop
        do_reset();
        for (int i = 0; i < 16; i++) access(1, 4'h0, 32'h60 + i, rd);
        mem_addr = BASE; mem_wdata = 32'h77; mem_wstrb = 4'hF; mem_valid = 1'b1;
        ok = 1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (mem_ready) ok = 0;
        end
        check("stall_no_ack", ok, 1);
        tx_tready = 1'b1;
        n = 0;
        while (!mem_ready && n < 20) begin
            cycle();
            n++;
        end
        mem_valid = 1'b0;
        check("stall_release_ack", mem_ready, 1);
        check("stall_release_latency", n, 2);
        if (mem_ready) tx_q.push_back(8'h77);
        cycle();
        check("stall_ready_pulse", mem_ready, 0);
        drain();

        // Dropping instance: 17th write acked and discarded
        sel = 1;
        do_reset();
        for (int i = 0; i < 17; i++) access(1, 4'h0, 32'h80 + i, rd);
        access(0, 4'h4, 0, rd);
        check("drop_flag", rd[4], 1);
        check("drop_tx_count", rd[23:16], 16);
        access(1, 4'h8, 32'h8, rd);
        access(0, 4'h4, 0, rd);
        check("drop_flag_cleared", rd[4], 0);
        drain();
        sel = 0;

        // RX overflow and in-order reads
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = 8'h10 + 8'(i);
            cycle();
        end
        rx_tvalid = 1'b0;
        access(0, 4'h4, 0, rd);
        check("rx_count_full", rd[15:8], 16);
        check("rx_overflow_set", rd[3], 1);
        for (int i = 0; i < 16; i++) begin
            access(0, 4'h0, 0, rd);
            check($sformatf("rx_read_%0d", i), rd, 32'h110 + i);
        end
        access(0, 4'h0, 0, rd);
        check("rx_read_empty", rd, 0);
        access(1, 4'h8, 32'h4, rd);
        access(0, 4'h4, 0, rd);
        check("rx_overflow_cleared", rd[3], 0);

        // RX interrupt and out-of-window access
        do_reset();
        access(1, 4'h8, 32'h1, rd);
        rx_tvalid = 1'b1; rx_tdata = 8'h5A;
        cycle();
        rx_tvalid = 1'b0;
        check("irq_not_yet", irq, 0);
        cycle();
        check("irq_rx_set", irq, 1);
        access(0, 4'h0, 0, rd);
        check("irq_rx_data", rd, 32'h15A);
        check("irq_rx_cleared", irq, 0);
        mem_addr = BASE + 32'h10; mem_wstrb = 4'h0; mem_valid = 1'b1;
        ok = 1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (mem_ready) ok = 0;
        end
        mem_valid = 1'b0;
        check("out_of_window_no_ack", ok, 1);

        // Reset while a write sits in WAIT_TX
        do_reset();
        for (int i = 0; i < 16; i++) access(1, 4'h0, 32'hA0 + i, rd);
        mem_addr = BASE; mem_wdata = 32'hEE; mem_wstrb = 4'hF; mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        resetn = 1'b0;
        @(negedge clk);
        check("reset_stall_no_ack", mem_ready, 0);
        mem_valid = 1'b0;
        do_reset();
        check("reset_fifo_tx_idle", tx_tvalid, 0);
        access(0, 4'h4, 0, rd);
        check("reset_status", rd, 32'h6);

        // Randomized traffic against the model
        do_reset();
        rnd = 1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: access(1, 4'h0, $urandom, rd);
                4, 5, 6:    access(0, 4'h0, 0, rd);
                7:          access(0, 4'h4, 0, rd);
                8:          access(1, 4'h8, 32'($urandom_range(0, 15)), rd);
                default: begin
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++) cycle();
                end
            endcase
        end
        rnd = 0;
        rx_tvalid = 1'b0;
        drain();
        access(0, 4'h4, 0, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
